// File: rtl/cpri_rx_seq_ctrl_if.sv
// Bus between the CPRI receive front end and the sequence controller.
// master : drives the receive-valid strobe and configuration, observes the indices.
// slave  : the controller itself.
// i_cpri_rx_vld   receive word present this cycle
// i_rbg_size_cfg  requested RBG size (takes effect at a slot start)
// i_cwd_upd_req   level: new codeword set loaded in the idle bank
// o_cpri_rx_seq   word index within the basic group (0 when no word)
// o_sym_idx       symbol index within the slot
// o_sym_start     first word of a symbol
// o_slot_start    first word of a slot
// o_rbg_size      active RBG size
// o_cwd_bank_sel  active codeword bank
// o_cwd_upd_ack   one-cycle pulse on a bank swap
// o_err_gap       one-cycle pulse when valid drops inside a group
interface cpri_rx_seq_ctrl_if;
  logic       i_cpri_rx_vld;
  logic [1:0] i_rbg_size_cfg;
  logic       i_cwd_upd_req;
  logic [6:0] o_cpri_rx_seq;
  logic [3:0] o_sym_idx;
  logic       o_sym_start;
  logic       o_slot_start;
  logic [1:0] o_rbg_size;
  logic       o_cwd_bank_sel;
  logic       o_cwd_upd_ack;
  logic       o_err_gap;

  modport master (
    output i_cpri_rx_vld, i_rbg_size_cfg, i_cwd_upd_req,
    input  o_cpri_rx_seq, o_sym_idx, o_sym_start, o_slot_start,
           o_rbg_size, o_cwd_bank_sel, o_cwd_upd_ack, o_err_gap
  );

  modport slave (
    input  i_cpri_rx_vld, i_rbg_size_cfg, i_cwd_upd_req,
    output o_cpri_rx_seq, o_sym_idx, o_sym_start, o_slot_start,
           o_rbg_size, o_cwd_bank_sel, o_cwd_upd_ack, o_err_gap
  );
endinterface

// File: rtl/cpri_rx_seq_ctrl.sv
// CPRI receive sequence controller.
// Tracks word / group / symbol position of the incoming CPRI stream, flags
// symbol and slot starts, latches the RBG size and swaps the codeword bank on
// slot boundaries, and resynchronises after a valid gap inside a group.
// Ports:
//   i_clk      clock (rising edge)
//   i_reset_n  asynchronous active-low reset
//   bus        cpri_rx_seq_ctrl_if.slave (see interface header)
// The counters hold the position of the *next* word, so the per-word outputs
// are a zero-latency decode of registers qualified by the valid strobe.
module cpri_rx_seq_ctrl #(
  parameter int SEQ_LEN     = 96,
  parameter int GRP_PER_SYM = 66,
  parameter int NUM_SYM     = 14
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  cpri_rx_seq_ctrl_if.slave  bus
);

  localparam int              GW      = (GRP_PER_SYM > 1) ? $clog2(GRP_PER_SYM) : 1;
  localparam logic [6:0]      SEQ_MAX = 7'(SEQ_LEN - 1);
  localparam logic [GW-1:0]   GRP_MAX = GW'(GRP_PER_SYM - 1);
  localparam logic [3:0]      SYM_MAX = 4'(NUM_SYM - 1);

  typedef enum logic [1:0] {IDLE, RUN, RESYNC} state_t;

  state_t        state;
  logic [6:0]    seq_q;
  logic [GW-1:0] grp_q;
  logic [3:0]    sym_q;
  logic [1:0]    rbg_q;
  logic          bank_q;

  logic vld_ok, sym_start, slot_start, upd_slot, swap, gap;

  // Reset gates the combinational decode so every output is 0 while held.
  assign vld_ok     = i_reset_n & bus.i_cpri_rx_vld;
  assign sym_start  = vld_ok && (seq_q == '0) && (grp_q == '0);
  assign slot_start = sym_start && (sym_q == '0);
  // The slot start that re-enters from IDLE/RESYNC must not touch bank or RBG.
  assign upd_slot   = slot_start && (state == RUN);
  assign swap       = upd_slot && bus.i_cwd_upd_req;
  // A drop at seq=0 is a legal inter-group pause; anywhere else is an error.
  assign gap        = (state == RUN) && !bus.i_cpri_rx_vld && (seq_q != '0);

  assign bus.o_cpri_rx_seq  = vld_ok ? seq_q : '0;
  assign bus.o_sym_idx      = sym_q;
  assign bus.o_sym_start    = sym_start;
  assign bus.o_slot_start   = slot_start;
  assign bus.o_rbg_size     = upd_slot ? bus.i_rbg_size_cfg : rbg_q;
  assign bus.o_cwd_bank_sel = bank_q ^ swap;
  assign bus.o_cwd_upd_ack  = swap;
  assign bus.o_err_gap      = gap;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state  <= IDLE;
      seq_q  <= '0;
      grp_q  <= '0;
      sym_q  <= '0;
      rbg_q  <= '0;
      bank_q <= 1'b0;
    end else begin
      if (bus.i_cpri_rx_vld) begin
        // IDLE/RESYNC hold all counters at 0, so the entry word advances
        // exactly like a slot-start word in RUN.
        state <= RUN;
        if (seq_q == SEQ_MAX) begin
          seq_q <= '0;
          if (grp_q == GRP_MAX) begin
            grp_q <= '0;
            sym_q <= (sym_q == SYM_MAX) ? 4'd0 : sym_q + 4'd1;
          end else begin
            grp_q <= grp_q + 1'b1;
          end
        end else begin
          seq_q <= seq_q + 7'd1;
        end
      end else if (gap) begin
        state <= RESYNC;
        seq_q <= '0;
        grp_q <= '0;
        sym_q <= '0;
      end
      if (upd_slot) rbg_q  <= bus.i_rbg_size_cfg;
      if (swap)     bank_q <= ~bank_q;
    end
  end

endmodule

// File: tb/tb_cpri_rx_seq_ctrl.sv
// Directed bench for cpri_rx_seq_ctrl with a reduced frame:
// 4 words/group, 3 groups/symbol, 4 symbols/slot -> 12 words/symbol, 48/slot.
module tb_cpri_rx_seq_ctrl;
  localparam int SL = 4, GP = 3, NS = 4;
  localparam int WPS = SL * GP;       // words per symbol
  localparam int WPSLOT = WPS * NS;   // words per slot

  logic i_clk = 1'b0;
  logic i_reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  cpri_rx_seq_ctrl_if bus ();

  cpri_rx_seq_ctrl #(.SEQ_LEN(SL), .GRP_PER_SYM(GP), .NUM_SYM(NS)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .bus       (bus)
  );

  always #5 i_clk = ~i_clk;

  // Leaves the bench at posedge+1 with reset released and valid low.
  task automatic do_reset();
    i_reset_n = 1'b0;
    bus.i_cpri_rx_vld = 1'b0;
    bus.i_rbg_size_cfg = 2'd0;
    bus.i_cwd_upd_req = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_reset_n = 1'b1;
  endtask

  task automatic run_words(input int n);
    for (int i = 0; i < n; i++) begin
      bus.i_cpri_rx_vld = 1'b1;
      @(posedge i_clk); #1;
    end
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    bus.i_cpri_rx_vld = 1'b1;
    bus.i_rbg_size_cfg = 2'd3;
    bus.i_cwd_upd_req = 1'b1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    n_cmp++; if (bus.o_cpri_rx_seq !== 7'd0) begin n_bad++; $display("FAIL rst_seq: got %0d want 0", bus.o_cpri_rx_seq); end
    n_cmp++; if (bus.o_sym_idx !== 4'd0) begin n_bad++; $display("FAIL rst_sym: got %0d want 0", bus.o_sym_idx); end
    n_cmp++; if ({bus.o_sym_start, bus.o_slot_start} !== 2'b00) begin n_bad++; $display("FAIL rst_starts: got %b want 00", {bus.o_sym_start, bus.o_slot_start}); end
    n_cmp++; if (bus.o_rbg_size !== 2'd0) begin n_bad++; $display("FAIL rst_rbg: got %0d want 0", bus.o_rbg_size); end
    n_cmp++; if ({bus.o_cwd_bank_sel, bus.o_cwd_upd_ack, bus.o_err_gap} !== 3'b000) begin n_bad++; $display("FAIL rst_bank_ack_err: got %b want 000", {bus.o_cwd_bank_sel, bus.o_cwd_upd_ack, bus.o_err_gap}); end
  endtask

  // Two full slots of back-to-back words, every index checked against k.
  task automatic test_continuous();
    int max_sym;
    int n_sym_starts;
    int n_slot_starts;
    max_sym = 0; n_sym_starts = 0; n_slot_starts = 0;
    do_reset();
    for (int k = 0; k < 2 * WPSLOT; k++) begin
      bus.i_cpri_rx_vld = 1'b1;
      @(negedge i_clk);
      n_cmp++; if (bus.o_cpri_rx_seq !== 7'(k % SL)) begin n_bad++; $display("FAIL cont_seq k=%0d: got %0d want %0d", k, bus.o_cpri_rx_seq, k % SL); end
      n_cmp++; if (bus.o_sym_idx !== 4'((k / WPS) % NS)) begin n_bad++; $display("FAIL cont_sym k=%0d: got %0d want %0d", k, bus.o_sym_idx, (k / WPS) % NS); end
      n_cmp++; if (bus.o_sym_start !== (k % WPS == 0)) begin n_bad++; $display("FAIL cont_sym_start k=%0d: got %b want %b", k, bus.o_sym_start, (k % WPS == 0)); end
      n_cmp++; if (bus.o_slot_start !== (k % WPSLOT == 0)) begin n_bad++; $display("FAIL cont_slot_start k=%0d: got %b want %b", k, bus.o_slot_start, (k % WPSLOT == 0)); end
      if (int'(bus.o_sym_idx) > max_sym) max_sym = int'(bus.o_sym_idx);
      if (bus.o_sym_start === 1'b1) n_sym_starts++;
      if (bus.o_slot_start === 1'b1) n_slot_starts++;
      @(posedge i_clk); #1;
    end
    n_cmp++; if (max_sym != NS - 1) begin n_bad++; $display("FAIL cont_max_sym: got %0d want %0d", max_sym, NS - 1); end
    n_cmp++; if (n_sym_starts != 2 * NS) begin n_bad++; $display("FAIL cont_sym_starts: got %0d want %0d", n_sym_starts, 2 * NS); end
    n_cmp++; if (n_slot_starts != 2) begin n_bad++; $display("FAIL cont_slot_starts: got %0d want 2", n_slot_starts); end
    bus.i_cpri_rx_vld = 1'b0;
  endtask

  // Valid drops for 5 cycles right at a group boundary: counters must hold.
  task automatic test_gap_boundary();
    do_reset();
    run_words(SL);
    for (int i = 0; i < 5; i++) begin
      bus.i_cpri_rx_vld = 1'b0;
      @(negedge i_clk);
      n_cmp++; if (bus.o_err_gap !== 1'b0) begin n_bad++; $display("FAIL gb_err i=%0d: got %b want 0", i, bus.o_err_gap); end
      n_cmp++; if (bus.o_cpri_rx_seq !== 7'd0) begin n_bad++; $display("FAIL gb_seq_idle i=%0d: got %0d want 0", i, bus.o_cpri_rx_seq); end
      @(posedge i_clk); #1;
    end
    // Resume in group 1: no symbol start until word 12.
    for (int k = SL; k <= WPS; k++) begin
      bus.i_cpri_rx_vld = 1'b1;
      @(negedge i_clk);
      n_cmp++; if (bus.o_cpri_rx_seq !== 7'(k % SL)) begin n_bad++; $display("FAIL gb_seq k=%0d: got %0d want %0d", k, bus.o_cpri_rx_seq, k % SL); end
      n_cmp++; if (bus.o_sym_start !== (k == WPS)) begin n_bad++; $display("FAIL gb_sym_start k=%0d: got %b want %b", k, bus.o_sym_start, (k == WPS)); end
      @(posedge i_clk); #1;
    end
    n_cmp++; if (bus.o_sym_idx !== 4'd1) begin n_bad++; $display("FAIL gb_sym_idx: got %0d want 1", bus.o_sym_idx); end
    bus.i_cpri_rx_vld = 1'b0;
  endtask

  // Valid drops mid-group: one error pulse, then restart as a slot start.
  task automatic test_gap_mid();
    do_reset();
    run_words(WPS + 2);              // next word would be seq=2, sym=1
    bus.i_cpri_rx_vld = 1'b0;
    @(negedge i_clk);
    n_cmp++; if (bus.o_err_gap !== 1'b1) begin n_bad++; $display("FAIL gm_err_pulse: got %b want 1", bus.o_err_gap); end
    @(posedge i_clk); #1;
    @(negedge i_clk);
    n_cmp++; if (bus.o_err_gap !== 1'b0) begin n_bad++; $display("FAIL gm_err_single: got %b want 0", bus.o_err_gap); end
    @(posedge i_clk); #1;
    bus.i_cpri_rx_vld = 1'b1;
    @(negedge i_clk);
    n_cmp++; if (bus.o_cpri_rx_seq !== 7'd0) begin n_bad++; $display("FAIL gm_seq: got %0d want 0", bus.o_cpri_rx_seq); end
    n_cmp++; if (bus.o_sym_idx !== 4'd0) begin n_bad++; $display("FAIL gm_sym: got %0d want 0", bus.o_sym_idx); end
    n_cmp++; if (bus.o_slot_start !== 1'b1) begin n_bad++; $display("FAIL gm_slot_start: got %b want 1", bus.o_slot_start); end
    @(posedge i_clk); #1;
    bus.i_cpri_rx_vld = 1'b0;
  endtask

  // RBG change mid-slot waits for the next slot start.
  task automatic test_rbg();
    do_reset();
    run_words(2 * WPS);              // now at sym=2
    bus.i_rbg_size_cfg = 2'd2;
    for (int k = 2 * WPS; k <= WPSLOT + 2; k++) begin
      if (k == WPSLOT + 2) bus.i_rbg_size_cfg = 2'd1;
      bus.i_cpri_rx_vld = 1'b1;
      @(negedge i_clk);
      n_cmp++; if (bus.o_rbg_size !== ((k < WPSLOT) ? 2'd0 : 2'd2)) begin n_bad++; $display("FAIL rbg k=%0d: got %0d want %0d", k, bus.o_rbg_size, (k < WPSLOT) ? 0 : 2); end
      @(posedge i_clk); #1;
    end
    bus.i_cpri_rx_vld = 1'b0;
  endtask

  // Update request held for several slots; then a gap right before a slot
  // boundary must restart without swapping.
  task automatic test_bank();
    int acks;
    acks = 0;
    do_reset();
    bus.i_cwd_upd_req = 1'b1;
    for (int k = 0; k < 4 * WPSLOT - 1; k++) begin
      bus.i_cpri_rx_vld = 1'b1;
      @(negedge i_clk);
      n_cmp++; if (bus.o_cwd_upd_ack !== (k > 0 && k % WPSLOT == 0)) begin n_bad++; $display("FAIL bank_ack k=%0d: got %b want %b", k, bus.o_cwd_upd_ack, (k > 0 && k % WPSLOT == 0)); end
      n_cmp++; if (bus.o_cwd_bank_sel !== 1'((k / WPSLOT) % 2)) begin n_bad++; $display("FAIL bank_sel k=%0d: got %b want %0d", k, bus.o_cwd_bank_sel, (k / WPSLOT) % 2); end
      if (bus.o_cwd_upd_ack === 1'b1) acks++;
      @(posedge i_clk); #1;
    end
    n_cmp++; if (acks != 3) begin n_bad++; $display("FAIL bank_ack_count: got %0d want 3", acks); end
    bus.i_cpri_rx_vld = 1'b0;
    @(negedge i_clk);
    n_cmp++; if (bus.o_err_gap !== 1'b1) begin n_bad++; $display("FAIL bank_gap_err: got %b want 1", bus.o_err_gap); end
    @(posedge i_clk); #1;
    bus.i_cpri_rx_vld = 1'b1;
    @(negedge i_clk);
    n_cmp++; if (bus.o_slot_start !== 1'b1) begin n_bad++; $display("FAIL bank_resync_slot: got %b want 1", bus.o_slot_start); end
    n_cmp++; if ({bus.o_cwd_bank_sel, bus.o_cwd_upd_ack} !== 2'b10) begin n_bad++; $display("FAIL bank_resync_noswap: got %b want 10", {bus.o_cwd_bank_sel, bus.o_cwd_upd_ack}); end
    @(posedge i_clk); #1;
    bus.i_cpri_rx_vld = 1'b0;
    bus.i_cwd_upd_req = 1'b0;
  endtask

  // Reset dropped between clock edges mid-slot.
  task automatic test_async_reset();
    do_reset();
    bus.i_cwd_upd_req = 1'b1;
    bus.i_rbg_size_cfg = 2'd3;
    run_words(WPSLOT + 1);           // swap at word 48 -> bank 1, rbg 3
    bus.i_cwd_upd_req = 1'b0;
    run_words(2 * WPS + 1);          // now at sym=2, seq=2
    bus.i_cpri_rx_vld = 1'b1;
    @(negedge i_clk);
    n_cmp++; if ({bus.o_cwd_bank_sel, bus.o_rbg_size, bus.o_cpri_rx_seq} !== {1'b1, 2'd3, 7'd2}) begin n_bad++; $display("FAIL ar_pre: got bank=%b rbg=%0d seq=%0d want 1/3/2", bus.o_cwd_bank_sel, bus.o_rbg_size, bus.o_cpri_rx_seq); end
    @(posedge i_clk); #2;
    i_reset_n = 1'b0;
    #1;
    n_cmp++; if ({bus.o_cpri_rx_seq, bus.o_sym_idx} !== 11'd0) begin n_bad++; $display("FAIL ar_idx: got seq=%0d sym=%0d want 0/0", bus.o_cpri_rx_seq, bus.o_sym_idx); end
    n_cmp++; if ({bus.o_sym_start, bus.o_slot_start, bus.o_rbg_size, bus.o_cwd_bank_sel, bus.o_cwd_upd_ack, bus.o_err_gap} !== 7'd0) begin n_bad++; $display("FAIL ar_flags: got %b want 0000000", {bus.o_sym_start, bus.o_slot_start, bus.o_rbg_size, bus.o_cwd_bank_sel, bus.o_cwd_upd_ack, bus.o_err_gap}); end
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;
    bus.i_rbg_size_cfg = 2'd0;
    @(negedge i_clk);
    n_cmp++; if ({bus.o_cpri_rx_seq, bus.o_sym_idx, bus.o_slot_start} !== {7'd0, 4'd0, 1'b1}) begin n_bad++; $display("FAIL ar_restart: got seq=%0d sym=%0d slot=%b want 0/0/1", bus.o_cpri_rx_seq, bus.o_sym_idx, bus.o_slot_start); end
    @(posedge i_clk); #1;
    bus.i_cpri_rx_vld = 1'b0;
  endtask

  initial begin
    bus.i_cpri_rx_vld = 1'b0;
    bus.i_rbg_size_cfg = 2'd0;
    bus.i_cwd_upd_req = 1'b0;
    test_reset();
    test_continuous();
    test_gap_boundary();
    test_gap_mid();
    test_rbg();
    test_bank();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cpri_rx_seq_ctrl.md
CPRI_RX_SEQ_CTRL -- requirements
Module: cpri_rx_seq_ctrl

Interface
REQ-001 SHALL have parameter SEQ_LEN, default 96, meaning words per CPRI basic group; the sequence index wraps at SEQ_LEN-1.
REQ-002 SHALL have parameter GRP_PER_SYM, default 66, meaning groups per OFDM symbol.
REQ-003 SHALL have parameter NUM_SYM, default 14, meaning symbols per slot.
REQ-004 SHALL have port i_clk, input, 1, the single clock; all logic is synchronous to its rising edge.
REQ-005 SHALL have port i_reset_n, input, 1, reset; asynchronous assert, active-low.
REQ-006 SHALL have port i_cpri_rx_vld, input, 1, a CPRI receive word is present this cycle.
REQ-007 SHALL have port i_rbg_size_cfg, input, 2, the requested RBG size.
REQ-008 SHALL have port i_cwd_upd_req, input, 1, a level; a new codeword set is loaded in the idle bank.
REQ-009 SHALL have port o_cpri_rx_seq, output, 7, the word index within the group, driven to the dim-reduction datapath.
REQ-010 SHALL have port o_sym_idx, output, 4, the current symbol index.
REQ-011 SHALL have port o_sym_start, output, 1, a pulse on the first word of a symbol.
REQ-012 SHALL have port o_slot_start, output, 1, a pulse on the first word of a slot.
REQ-013 SHALL have port o_rbg_size, output, 2, the active RBG size.
REQ-014 SHALL have port o_cwd_bank_sel, output, 1, the active codeword bank (0/1).
REQ-015 SHALL have port o_cwd_upd_ack, output, 1, a one-cycle pulse when the bank swaps.
REQ-016 SHALL have port o_err_gap, output, 1, a one-cycle pulse on a valid gap inside a group.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, RESYNC.
REQ-018 IDLE -> RUN on the first cycle with i_cpri_rx_vld=1; that word gets seq=0, group=0, sym=0, and asserts o_sym_start=1 and o_slot_start=1 combinationally with the word.
REQ-019 In RUN, SHALL increment the seq counter on each valid word and wrap SEQ_LEN-1 -> 0.
REQ-020 On seq wrap, SHALL increment the group counter; on group wrap, GRP_PER_SYM-1 -> 0.
REQ-021 On group wrap, SHALL increment the symbol index; on symbol wrap, NUM_SYM-1 -> 0.
REQ-022 o_sym_start SHALL be 1 exactly on words with seq=0 and group=0.
REQ-023 o_slot_start SHALL additionally require sym=0.
REQ-024 o_cpri_rx_seq and o_sym_idx SHALL be registered and aligned to the same cycle as the word they index; latency is 0 relative to i_cpri_rx_vld.
REQ-025 When i_cpri_rx_vld=0 with seq!=0 in RUN, SHALL pulse o_err_gap, clear seq, group and sym, and go to RESYNC.
REQ-026 When i_cpri_rx_vld=0 with seq=0 (group boundary), SHALL hold all counters with no error.
REQ-027 RESYNC -> RUN on the next valid word, which is treated as a slot start (REQ-018 values).
REQ-028 o_cpri_rx_seq SHALL be forced to 0 whenever i_cpri_rx_vld=0.
REQ-029 o_rbg_size SHALL update from i_rbg_size_cfg only on o_slot_start cycles; mid-slot changes are ignored until the next slot.
REQ-030 On an o_slot_start cycle with i_cwd_upd_req=1, SHALL toggle o_cwd_bank_sel and pulse o_cwd_upd_ack in the same cycle.
REQ-031 o_cwd_upd_ack SHALL fire at most once per slot.
REQ-032 If i_cwd_upd_req stays high, SHALL swap again at the next slot.
REQ-033 Simultaneous gap and slot wrap: the gap takes priority, and no bank swap occurs.
REQ-034 Bank and RBG registers SHALL NOT change in IDLE or RESYNC.

Reset
REQ-035 While i_reset_n=0, SHALL hold the FSM in IDLE with all counters 0.
REQ-036 While i_reset_n=0, SHALL drive o_cpri_rx_seq=0, o_sym_idx=0, o_sym_start=0, o_slot_start=0, o_rbg_size=0, o_cwd_bank_sel=0, o_cwd_upd_ack=0, o_err_gap=0.
REQ-037 Reset asserted mid-slot SHALL take effect immediately (asynchronous).
REQ-038 After reset release, SHALL restart via IDLE on the next valid word.

Verification
REQ-039 Continuous vld for 96*66*14*2 cycles -> seq wraps 95->0 each 96 words; o_sym_start every 6336 words; o_slot_start at words 0 and 88704; o_sym_idx reaches 13.
REQ-040 vld low for 5 cycles exactly at seq=0 -> counters held, o_err_gap=0, resume seq=0 on the same group.
REQ-041 vld low at seq=40 -> o_err_gap single pulse, next valid word seq=0, sym=0, o_slot_start=1.
REQ-042 i_rbg_size_cfg=2 set at sym=5 -> o_rbg_size stays 0 until next o_slot_start, then 2.
REQ-043 i_cwd_upd_req held high for 3 slots -> o_cwd_bank_sel 0->1->0->1, one ack per slot start; gap at slot boundary -> no swap.
REQ-044 i_reset_n pulsed low at sym=7 -> all outputs 0 asynchronously; after release and next vld, seq=0 with o_slot_start=1.
